bcd_counter: RTL and testbench



---
 rtl/bcd_pkg.sv | 9 +
 rtl/bcd_digit.sv | 28 ++
 rtl/bcd_counter.sv | 66 ++++++
 tb/tb_bcd_counter.sv | 130 +++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// bcd_pkg: shared BCD digit type, bounds and validity check
package bcd_pkg;
  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_MIN = 4'd0;
  typedef logic [3:0] bcd_digit_t;
  function automatic logic is_bcd(bcd_digit_t d);
    return d <= BCD_MAX;
  endfunction
endpackage

// File: rtl/bcd_digit.sv
// bcd_digit: one BCD digit register with ripple carry/borrow
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       ld,
  input  logic [3:0] ld_val,
  input  logic       up,
  input  logic       dn,
  input  logic       cin,
  input  logic       bin,
  output logic [3:0] q,
  output logic       cout,
  output logic       bout
);
  bcd_digit_t r_q;
  assign q    = r_q;
  assign cout = cin & (r_q == BCD_MAX);
  assign bout = bin & (r_q == BCD_MIN);
  always_ff @(posedge clk or posedge reset)
    if (reset) r_q <= BCD_MIN;
    else if (clr) r_q <= BCD_MIN;
    else if (ld) r_q <= ld_val;
    else if (up && cin) r_q <= cout ? BCD_MIN : r_q + 4'd1;
    else if (dn && bin) r_q <= bout ? BCD_MAX : r_q - 4'd1;
endmodule

// File: rtl/bcd_counter.sv
// bcd_counter: N-digit BCD up/down counter with load, clear, wrap/saturate and flags
module bcd_counter
  import bcd_pkg::*;
#(
  parameter int N_DIGITS = 3,
  parameter bit WRAP     = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] din,
  input  logic                  inc,
  input  logic                  dec,
  output logic [4*N_DIGITS-1:0] bcd,
  output logic                  max_tick,
  output logic                  min_tick,
  output logic                  ovf,
  output logic                  err
);
  logic [N_DIGITS:0]   w_carry;
  logic [N_DIGITS:0]   w_borrow;
  logic [N_DIGITS-1:0] w_valid;
  logic                w_up, w_dn, w_ld, w_hit_hi, w_hit_lo;
  logic                r_ovf, r_err;
  assign w_carry[0]  = 1'b1;
  assign w_borrow[0] = 1'b1;
  assign w_up        = inc & ~dec & ~clr & ~load;
  assign w_dn        = dec & ~inc & ~clr & ~load;
  assign w_ld        = load & ~clr & (&w_valid);
  // the final carry/borrow out flags a bound crossing; saturation just gates it
  assign w_hit_hi    = w_up & w_carry[N_DIGITS];
  assign w_hit_lo    = w_dn & w_borrow[N_DIGITS];
  genvar k;
  generate
    for (k = 0; k < N_DIGITS; k++) begin : g_dig
      assign w_valid[k] = is_bcd(din[4*k +: 4]);
      bcd_digit u_dig (
        .clk    (clk),
        .reset  (reset),
        .clr    (clr),
        .ld     (w_ld),
        .ld_val (din[4*k +: 4]),
        .up     (w_up & (WRAP | ~w_carry[N_DIGITS])),
        .dn     (w_dn & (WRAP | ~w_borrow[N_DIGITS])),
        .cin    (w_carry[k]),
        .bin    (w_borrow[k]),
        .q      (bcd[4*k +: 4]),
        .cout   (w_carry[k+1]),
        .bout   (w_borrow[k+1])
      );
    end
  endgenerate
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_ovf <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_ovf <= w_hit_hi | w_hit_lo;
      r_err <= clr ? 1'b0 : (load & ~(&w_valid)) ? 1'b1 : r_err;
    end
  assign ovf      = r_ovf;
  assign err      = r_err;
  assign max_tick = bcd == {N_DIGITS{BCD_MAX}};
  assign min_tick = bcd == {N_DIGITS{BCD_MIN}};
endmodule

// File: tb/tb_bcd_counter.sv
// tb_bcd_counter: wrap and saturate counters against an integer reference model
module tb_bcd_counter;
  logic        clk = 1'b0, reset = 1'b1, clr = 1'b0, load = 1'b0, inc = 1'b0, dec = 1'b0;
  logic [11:0] din = '0;
  logic [11:0] bcd_o [2];
  logic        max_o [2], min_o [2], ovf_o [2], err_o [2];
  int          val [2];
  bit          m_ovf [2], m_err [2];
  int          n_chk = 0, n_pass = 0, ovf_cnt;

  bcd_counter #(.N_DIGITS(3), .WRAP(1'b1)) u_wrap (
    .clk(clk), .reset(reset), .clr(clr), .load(load), .din(din), .inc(inc), .dec(dec),
    .bcd(bcd_o[0]), .max_tick(max_o[0]), .min_tick(min_o[0]), .ovf(ovf_o[0]), .err(err_o[0]));
  bcd_counter #(.N_DIGITS(3), .WRAP(1'b0)) u_sat (
    .clk(clk), .reset(reset), .clr(clr), .load(load), .din(din), .inc(inc), .dec(dec),
    .bcd(bcd_o[1]), .max_tick(max_o[1]), .min_tick(min_o[1]), .ovf(ovf_o[1]), .err(err_o[1]));

  always #5 clk = ~clk;

  function automatic logic [11:0] to_bcd(int v);
    logic [11:0] r;
    for (int d = 0; d < 3; d++) r[4*d +: 4] = 4'((v / (10 ** d)) % 10);
    return r;
  endfunction

  function automatic bit din_ok(logic [11:0] x);
    for (int d = 0; d < 3; d++) if (x[4*d +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int from_bcd(logic [11:0] x);
    int s = 0;
    for (int d = 0; d < 3; d++) s += int'(x[4*d +: 4]) * (10 ** d);
    return s;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_all(string tag);
    for (int w = 0; w < 2; w++) begin
      check($sformatf("%s[%0d].bcd", tag, w), 32'(bcd_o[w]), 32'(to_bcd(val[w])));
      check($sformatf("%s[%0d].ovf", tag, w), 32'(ovf_o[w]), 32'(m_ovf[w]));
      check($sformatf("%s[%0d].err", tag, w), 32'(err_o[w]), 32'(m_err[w]));
      check($sformatf("%s[%0d].max", tag, w), 32'(max_o[w]), 32'(val[w] == 999));
      check($sformatf("%s[%0d].min", tag, w), 32'(min_o[w]), 32'(val[w] == 0));
    end
  endtask

  task automatic model_reset();
    for (int w = 0; w < 2; w++) begin
      val[w] = 0; m_ovf[w] = 0; m_err[w] = 0;
    end
  endtask

  task automatic step(string tag, bit c, bit l, logic [11:0] d, bit i, bit dc);
    clr = c; load = l; din = d; inc = i; dec = dc;
    @(posedge clk);
    #1;
    for (int w = 0; w < 2; w++) begin
      m_ovf[w] = 0;
      if (c) begin
        val[w] = 0; m_err[w] = 0;
      end else if (l) begin
        if (din_ok(d)) val[w] = from_bcd(d);
        else m_err[w] = 1;
      end else if (i && !dc) begin
        if (val[w] == 999) begin
          m_ovf[w] = 1; val[w] = (w == 0) ? 0 : 999;
        end else val[w]++;
      end else if (dc && !i) begin
        if (val[w] == 0) begin
          m_ovf[w] = 1; val[w] = (w == 0) ? 999 : 0;
        end else val[w]--;
      end
    end
    check_all(tag);
  endtask

  initial begin
    model_reset();
    #12 reset = 1'b0;
    #1 check_all("reset");
    ovf_cnt = 0;
    for (int n = 0; n < 1000; n++) begin
      step("inc1000", 0, 0, 12'h000, 1, 0);
      ovf_cnt += int'(ovf_o[0]);
    end
    check("wrap_ovf_count", 32'(ovf_cnt), 32'd1);
    check("wrap_end_min", 32'(min_o[0]), 32'd1);
    step("ld199", 0, 1, 12'h199, 0, 0);
    step("inc200", 0, 0, 12'h000, 1, 0);
    check("dbl_carry", 32'(bcd_o[0]), 32'h200);
    step("dec199", 0, 0, 12'h000, 0, 1);
    step("dec198", 0, 0, 12'h000, 0, 1);
    step("ld000", 0, 1, 12'h000, 0, 0);
    for (int n = 0; n < 3; n++) step("dec_low", 0, 0, 12'h000, 0, 1);
    check("sat_low_ovf", 32'(ovf_o[1]), 32'd1);
    step("ld999", 0, 1, 12'h999, 0, 0);
    for (int n = 0; n < 2; n++) step("inc_high", 0, 0, 12'h000, 1, 0);
    step("ld_bad", 0, 1, 12'h1A3, 0, 0);
    check("err_set", 32'(err_o[0]), 32'd1);
    step("ld123", 0, 1, 12'h123, 0, 0);
    step("clr", 1, 0, 12'h000, 0, 0);
    step("ld_inc", 0, 1, 12'h050, 1, 0);
    check("ld_over_inc", 32'(bcd_o[0]), 32'h050);
    step("inc_dec", 0, 0, 12'h000, 1, 1);
    step("clr_ld", 1, 1, 12'h777, 0, 0);
    step("ld457", 0, 1, 12'h457, 0, 0);
    step("inc458", 0, 0, 12'h000, 1, 0);
    reset = 1'b1;
    #2;
    model_reset();
    check_all("async_rst");
    #1 reset = 1'b0;
    step("resume", 0, 0, 12'h000, 1, 0);
    for (int n = 0; n < 400; n++) begin
      logic [11:0] d;
      int r;
      r = int'($urandom_range(0, 99));
      d = (r < 15) ? 12'($urandom) : (r < 25) ? 12'h999 : (r < 35) ? 12'h000 : to_bcd(int'($urandom_range(0, 999)));
      step("rand", r < 3, r >= 3 && r < 40, d, 1'($urandom), 1'($urandom));
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
